imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 7, instruction-memory address width; 128 words, matching the 7-bit PC.
REQ-002 Parameter ACK_TIMEOUT, default 255, maximum cycles WrEn may wait for WrAck.
REQ-003 CLOCK_50  in  1  sole clock; all logic on the rising edge.
REQ-004 Reset_n  in  1  reset, synchronous, active-low.
REQ-005 Nibble  in  4  hex digit from switches.
REQ-006 Enter  in  1  single-cycle strobe (debounced key); accept Nibble.
REQ-007 Start  in  1  single-cycle strobe; open a load session at Base.
REQ-008 Finish  in  1  single-cycle strobe; close the session.
REQ-009 Base  in  ADDR_W  first write address of a session.
REQ-010 WrAck  in  1  memory accepts the current write.
REQ-011 WrEn  out  1  write request.
REQ-012 WrAddr  out  ADDR_W  write address.
REQ-013 WrData  out  16  write data.
REQ-014 Word  out  16  partially assembled word, for HEX display.
REQ-015 Digit  out  2  nibbles collected in the current word.
REQ-016 Count  out  ADDR_W+1  words written this session.
REQ-017 Busy  out  1  state is not IDLE.
REQ-018 Full  out  1  the last address was written.
REQ-019 Err  out  1  sticky ack-timeout flag.

Function
REQ-020 The FSM SHALL have four states:
- IDLE: Start -> COLLECT; WrAddr<=Base, Word<=0, Digit<=0, Count<=0, Err<=0.
- COLLECT: Enter -> Word<={Word[11:0],Nibble}, Digit+1. Enter with Digit==3 -> WRITE, WrData<=assembled word, Digit<=0. Finish -> IDLE, partial word discarded.
- WRITE: WrEn=1; WrAddr and WrData held stable until WrAck. On WrAck, Count+1. If WrAddr==2^ADDR_W-1 -> DONE; otherwise WrAddr+1 and -> COLLECT.
- DONE: Full=1; Start -> COLLECT as in IDLE; Finish -> IDLE.
REQ-021 Latency: the 4th Enter in cycle n SHALL give WrEn=1 in cycle n+1; WrAck in cycle m SHALL give WrEn=0 in cycle m+1.
REQ-022 Enter and Finish SHALL be ignored in WRITE; Enter SHALL be ignored in IDLE and DONE.
REQ-023 Start in any state SHALL restart the session exactly as from IDLE, including abandoning a pending write.
REQ-024 Simultaneous strobes SHALL be resolved by priority: Start > Finish > Enter.
REQ-025 WrAck SHALL be ignored while WrEn=0.
REQ-026 WrEn held for ACK_TIMEOUT cycles without WrAck SHALL set Err=1 and go to IDLE; the word is not counted.
REQ-027 WrAddr SHALL never wrap; Full SHALL clear only on Start or reset.

Reset
REQ-028 Reset_n=0 at a clock edge SHALL force IDLE; WrEn, Word, Digit, Count, Busy, Full and Err = 0; WrAddr = 0; WrData = 0.
REQ-029 Reset mid-WRITE SHALL drop WrEn the next cycle with no further handshake.

Configuration
REQ-030 IMEM_LOADER_CHECKSUM_EN:
- Defined: add output Csum[15:0]; cleared on Start and on reset; XOR-accumulates WrData on each accepted WrAck.
- Undefined: the port and its logic are absent.

Structure
REQ-031 Package imem_loader_pkg SHALL hold the state enum (IDLE, COLLECT, WRITE, DONE), NIBBLES=4 and DATA_W=16.
REQ-032 Single module, no sub-module; the timeout counter is inline.

Verification
REQ-033 Reset, then Start with Base=7'h10, then Enter nibbles 1,2,3,4 -> WrEn next cycle, WrAddr=7'h10, WrData=16'h1234; WrAck -> Count=1, WrAddr=7'h11.
REQ-034 Base=7'h7F, one word, WrAck -> Full=1, state DONE; a further Enter is ignored and WrEn stays 0.
REQ-035 Enter 2 nibbles, then Finish -> IDLE, Digit=0, no write issued.
REQ-036 WrAck withheld 255 cycles -> Err=1, IDLE, Count unchanged; the next Start clears Err.
REQ-037 Start and Enter in the same cycle -> session restarted, Digit=0; Reset_n=0 during WRITE -> WrEn=0 next cycle.
REQ-038 With IMEM_LOADER_CHECKSUM_EN defined, words 16'hA5A5 and 16'h0F0F -> Csum=16'hAAAA.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package imem_loader_pkg;

  // Loader session states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Hex digits per instruction word and the resulting word width.
  localparam int NIBBLES = 4;
  localparam int DATA_W  = 16;

endpackage

// File: rtl/imem_loader_if.sv
// Write port between the loader and the instruction memory.
// Latency: n/a (signal bundle only).
// Backpressure: WrEn stays asserted with stable WrAddr/WrData until WrAck.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 7
);

  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic              WrAck;

  // Loader side issues the write, memory side acknowledges it.
  modport master (output WrEn, WrAddr, WrData, input WrAck);
  modport slave  (input WrEn, WrAddr, WrData, output WrAck);

endinterface

// File: rtl/imem_loader.sv
// Assembles hex digits into 16-bit words and writes them to consecutive imem addresses.
// Latency: 4th Enter -> WrEn next cycle; WrAck -> WrEn low next cycle.
// Backpressure: holds the write until WrAck, gives up after ACK_TIMEOUT cycles (sets Err).
// Optional: define IMEM_LOADER_CHECKSUM_EN to add the Csum XOR checksum output.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                CLOCK_50,
  input  logic                Reset_n,
  input  logic [3:0]          Nibble,
  input  logic                Enter,
  input  logic                Start,
  input  logic                Finish,
  input  logic [ADDR_W-1:0]   Base,
  imem_loader_if.master       wr,
  output logic [DATA_W-1:0]   Word,
  output logic [1:0]          Digit,
  output logic [ADDR_W:0]     Count,
  output logic                Busy,
  output logic                Full,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic                Err,
  output logic [DATA_W-1:0]   Csum
`else
  output logic                Err
`endif
);

  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [1:0]        DIG_LAST  = 2'(NIBBLES - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   word_q,  word_d;
  logic [1:0]          digit_q, digit_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic                full_q,  full_d;
  logic                err_q,   err_d;
  logic [TMR_W-1:0]    tmr_q,   tmr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q,  csum_d;
`endif

  logic [DATA_W-1:0]   shifted;
  assign shifted = {word_q[DATA_W-5:0], Nibble};

  // State and datapath registers; synchronous active-low reset clears everything.
  always_ff @(posedge CLOCK_50) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      digit_q <= '0;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      digit_q <= digit_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      full_q  <= full_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Next-state logic; Start beats Finish beats Enter, and Start restarts from any state.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    digit_d = digit_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    full_d  = full_q;
    err_d   = err_q;
    tmr_d   = tmr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    if (Start) begin
      // Abandons any pending write; Full and Err only clear here (or on reset).
      state_d = COLLECT;
      addr_d  = Base;
      word_d  = '0;
      digit_d = '0;
      count_d = '0;
      err_d   = 1'b0;
      full_d  = 1'b0;
      tmr_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: ;
        COLLECT: begin
          if (Finish) begin
            state_d = IDLE;
            word_d  = '0;
            digit_d = '0;
          end else if (Enter) begin
            word_d = shifted;
            if (digit_q == DIG_LAST) begin
              digit_d = '0;
              data_d  = shifted;
              tmr_d   = '0;
              state_d = WRITE;
            end else begin
              digit_d = digit_q + 2'd1;
            end
          end
        end
        WRITE: begin
          // Enter/Finish are deliberately ignored while a write is outstanding.
          if (wr.WrAck) begin
            count_d = count_q + CNT_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d  = csum_q ^ data_q;
`endif
            if (addr_q == ADDR_LAST) begin
              // Top of memory: stop rather than wrap.
              full_d  = 1'b1;
              state_d = DONE;
            end else begin
              addr_d  = addr_q + ADDR_ONE;
              state_d = COLLECT;
            end
          end else if (tmr_q == TMR_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        DONE: begin
          if (Finish) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign wr.WrEn   = (state_q == WRITE);
  assign wr.WrAddr = addr_q;
  assign wr.WrData = data_q;
  assign Word      = word_q;
  assign Digit     = digit_q;
  assign Count     = count_q;
  assign Busy      = (state_q != IDLE);
  assign Full      = full_q;
  assign Err       = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign Csum      = csum_q;
`endif

endmodule
